// File: rtl/pulse_pkg.sv
// -----------------------------------------------------------------------------
// pulse_pkg
// Shared definitions for the pulse-train sequencer:
//   - seq_state_e      : sequencer FSM state encoding
//   - TIME_W           : width of the timecount loaded into the pulse block
//   - WD_W             : width of the WAIT-state watchdog counter / limit
//   - WD_LIMIT_DEFAULT : default watchdog limit in clk_sys cycles
//   - hi_word()        : formats the upper timecount bits as the high load word
// -----------------------------------------------------------------------------
package pulse_pkg;

  localparam int unsigned TIME_W = 20;
  localparam int unsigned WD_W   = 24;

  localparam logic [WD_W-1:0] WD_LIMIT_DEFAULT = 24'd4194304;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD_LO = 3'd1,
    LOAD_HI = 3'd2,
    FIRE    = 3'd3,
    WAIT    = 3'd4,
    FIN     = 3'd5
  } seq_state_e;

  // The pulse block takes the upper 4 timecount bits zero-extended to a word.
  function automatic logic [15:0] hi_word(input logic [TIME_W-1:0] t);
    return {12'd0, t[TIME_W-1:16]};
  endfunction

endpackage

// File: rtl/seq_watchdog.sv
// -----------------------------------------------------------------------------
// seq_watchdog
// Counts cycles while enabled and flags expiry on the cycle in which the
// count reaches the limit (i.e. the limit-th enabled cycle since clear).
// Ports:
//   clk_sys    in   system clock
//   rst_n      in   synchronous active-low reset
//   clear_i    in   zero the counter (has priority over enable_i)
//   enable_i   in   count this cycle
//   limit_i    in   expiry limit in enabled cycles
//   expired_o  out  combinational: this enabled cycle is the limit-th one
// -----------------------------------------------------------------------------
module seq_watchdog
  import pulse_pkg::*;
(
  input  logic            clk_sys,
  input  logic            rst_n,
  input  logic            clear_i,
  input  logic            enable_i,
  input  logic [WD_W-1:0] limit_i,
  output logic            expired_o
);

  logic [WD_W-1:0] count_q;
  logic [WD_W-1:0] count_d;
  logic            at_max_s;

  assign at_max_s = (count_q == {WD_W{1'b1}});

  // Extra bit so count+1 cannot overflow before the compare.
  assign expired_o = enable_i &&
                     (({1'b0, count_q} + {{WD_W{1'b0}}, 1'b1}) >= {1'b0, limit_i});

  // Next-count selection: clear wins, count saturates instead of wrapping.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = {WD_W{1'b0}};
    end else if (enable_i && !at_max_s) begin
      count_d = count_q + {{(WD_W-1){1'b0}}, 1'b1};
    end else begin
      count_d = count_q;
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      count_q <= {WD_W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/pulse_seq_ctrl.sv
// -----------------------------------------------------------------------------
// pulse_seq_ctrl
// Sequences a pulse train on an external pulse block: loads the 20-bit
// timecount as a low and a high word, then repeatedly strobes start and waits
// for the block's end-of-cycle flag until echo_num cycles have completed.
// A watchdog bounds each WAIT; abort returns to IDLE at once.
// Ports:
//   clk_sys          in   system clock
//   rst_n            in   synchronous active-low reset
//   seq_start        in   single-cycle run request (ignored while busy)
//   seq_abort        in   stop the train immediately
//   echo_num[15:0]   in   number of pulse cycles to run
//   time_lo[15:0]    in   timecount [15:0]
//   time_hi[3:0]     in   timecount [19:16]
//   pluse_over_n     in   active-low end-of-cycle flag from the pulse block
//   pluseload        out  load strobe
//   pluseloadchoice  out  load word select (0 low, 1 high)
//   plusedatain      out  load data (0 unless loading)
//   plusestart       out  start strobe
//   busy             out  train in progress
//   done             out  single-cycle normal-completion pulse
//   wd_err           out  sticky watchdog error
//   echo_cnt[15:0]   out  completed pulse cycles
// All outputs are driven straight from flops; each flop is loaded from the
// decode of the *next* state so the output lines up with the state it belongs to.
// -----------------------------------------------------------------------------
module pulse_seq_ctrl
  import pulse_pkg::*;
#(
  parameter logic [WD_W-1:0] WD_LIMIT = WD_LIMIT_DEFAULT
) (
  input  logic        clk_sys,
  input  logic        rst_n,
  input  logic        seq_start,
  input  logic        seq_abort,
  input  logic [15:0] echo_num,
  input  logic [15:0] time_lo,
  input  logic [3:0]  time_hi,
  input  logic        pluse_over_n,
  output logic        pluseload,
  output logic        pluseloadchoice,
  output logic [15:0] plusedatain,
  output logic        plusestart,
  output logic        busy,
  output logic        done,
  output logic        wd_err,
  output logic [15:0] echo_cnt
);

  seq_state_e        state_q, state_d;
  logic [15:0]       num_q, num_d;
  logic [TIME_W-1:0] time_q, time_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [15:0]       cnt_inc_s;
  logic              wd_err_q, wd_err_d;

  logic              load_q, load_d;
  logic              choice_q, choice_d;
  logic [15:0]       data_q, data_d;
  logic              start_q, start_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              wd_expired_s;
  logic              wd_clear_s;
  logic              wd_enable_s;

  assign cnt_inc_s   = cnt_q + 16'd1;
  assign wd_clear_s  = (state_q == FIRE);
  assign wd_enable_s = (state_q == WAIT);

  seq_watchdog u_wd (
    .clk_sys   (clk_sys),
    .rst_n     (rst_n),
    .clear_i   (wd_clear_s),
    .enable_i  (wd_enable_s),
    .limit_i   (WD_LIMIT),
    .expired_o (wd_expired_s)
  );

  // Next-state, latched-parameter and counter logic.
  always_comb begin
    state_d  = state_q;
    num_d    = num_q;
    time_d   = time_q;
    cnt_d    = cnt_q;
    wd_err_d = wd_err_q;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (seq_start) begin
          if (echo_num != 16'd0) begin
            num_d    = echo_num;
            time_d   = {time_hi, time_lo};
            cnt_d    = 16'd0;
            wd_err_d = 1'b0;
            state_d  = LOAD_LO;
          end else begin
            // Empty train: report completion without touching the pulse block.
            cnt_d  = 16'd0;
            done_d = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      LOAD_LO: state_d = LOAD_HI;
      LOAD_HI: state_d = FIRE;
      FIRE:    state_d = WAIT;
      WAIT: begin
        // Completion is checked before expiry so a coincident flag still counts.
        if (!pluse_over_n) begin
          cnt_d = cnt_inc_s;
          if (cnt_inc_s == num_q) begin
            state_d = FIN;
          end else begin
            state_d = FIRE;
          end
        end else if (wd_expired_s) begin
          wd_err_d = 1'b1;
          state_d  = IDLE;
        end else begin
          state_d = WAIT;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Abort overrides whatever the active state decided this cycle.
    if (seq_abort && (state_q != IDLE)) begin
      state_d  = IDLE;
      cnt_d    = cnt_q;
      wd_err_d = wd_err_q;
      done_d   = 1'b0;
    end else begin
      done_d = done_d | (state_d == FIN);
    end
  end

  // Output decode from the next state, feeding the output flops.
  always_comb begin
    load_d   = 1'b0;
    choice_d = 1'b0;
    data_d   = 16'd0;
    start_d  = 1'b0;
    busy_d   = (state_d != IDLE);
    case (state_d)
      LOAD_LO: begin
        load_d = 1'b1;
        data_d = time_d[15:0];
      end
      LOAD_HI: begin
        load_d   = 1'b1;
        choice_d = 1'b1;
        data_d   = hi_word(time_d);
      end
      FIRE: begin
        start_d = 1'b1;
      end
      default: begin
        load_d = 1'b0;
      end
    endcase
  end

  // State, parameter and output registers with synchronous reset.
  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      num_q    <= 16'd0;
      time_q   <= {TIME_W{1'b0}};
      cnt_q    <= 16'd0;
      wd_err_q <= 1'b0;
      load_q   <= 1'b0;
      choice_q <= 1'b0;
      data_q   <= 16'd0;
      start_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      num_q    <= num_d;
      time_q   <= time_d;
      cnt_q    <= cnt_d;
      wd_err_q <= wd_err_d;
      load_q   <= load_d;
      choice_q <= choice_d;
      data_q   <= data_d;
      start_q  <= start_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign pluseload       = load_q;
  assign pluseloadchoice = choice_q;
  assign plusedatain     = data_q;
  assign plusestart      = start_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign wd_err          = wd_err_q;
  assign echo_cnt        = cnt_q;

endmodule
